// File: rtl/edge_evt_arb_pkg.sv
// Shared types and helpers for the edge event arbiter.
// Optional feature macro: EDGE_EVT_ARB_FALL_EN (falling edges become events too).
package edge_evt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Width of the post-acceptance idle counter (GAP_CYC is at most 255).
    localparam int GAP_W = 8;

`ifdef EDGE_EVT_ARB_FALL_EN
    // Each channel owns a rise slot and a fall slot.
    localparam int SLOTS_PER_CH = 2;
`else
    localparam int SLOTS_PER_CH = 1;
`endif

    // Bits needed to index n items; never less than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_evt_arb_if.sv
// Event handshake between the arbiter (master) and its consumer (slave).
// With EDGE_EVT_ARB_FALL_EN defined the bundle also carries evt_fall.
interface edge_evt_arb_if #(
    parameter int N = 4
) ();
    import edge_evt_arb_pkg::*;

    localparam int IW = id_w(N);

    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic          evt_ready;
`ifdef EDGE_EVT_ARB_FALL_EN
    logic          evt_fall;

    modport master (output evt_valid, evt_id, evt_fall, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_fall, output evt_ready);
`else
    modport master (output evt_valid, evt_id, input evt_ready);
    modport slave  (input evt_valid, evt_id, output evt_ready);
`endif

endinterface

// File: rtl/edge_evt_arb_edge_det.sv
// Single-channel edge detector. edges[0] flags a rising edge; when NE is 2,
// edges[1] flags a falling edge. The previous-sample register resets to
// RST_VAL so a channel already high out of reset can count as a rise.
module edge_det #(
    parameter int NE      = 1,
    parameter bit RST_VAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig,
    output logic [NE-1:0] edges
);

    logic prev;

    // Remember last cycle's level.
    always_ff @(posedge clk) begin
        if (rst) prev <= RST_VAL;
        else     prev <= sig;
    end

    generate
        if (NE == 2) begin : g_both
            assign edges = {~sig & prev, sig & ~prev};
        end else begin : g_rise
            assign edges = sig & ~prev;
        end
    endgenerate

endmodule

// File: rtl/edge_evt_arb.sv
// Edge event arbiter: turns edges on N level inputs into a stream of
// one-at-a-time events, picked round-robin, with sticky overflow flags.
// Optional macro EDGE_EVT_ARB_FALL_EN: falling edges are events as well and
// evt_fall on the interface tells the consumer which kind was offered.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | nothing offered; picks the next pending slot if any
// OFFER | evt_valid high, evt_id frozen until the consumer takes it
// GAP   | enforced quiet time of GAP_CYC cycles after an acceptance
module edge_evt_arb
    import edge_evt_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int GAP_CYC = 0,
    parameter bit RST_VAL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          sig,
    edge_evt_arb_if.master        evt,
    output logic [N-1:0]          ovf,
    input  logic                  ovf_clr
);

    localparam int SPC = SLOTS_PER_CH;
    localparam int M   = N * SPC;
    localparam int SW  = id_w(M);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    logic [M-1:0]     slot_edge;
    logic [M-1:0]     pend;
    logic [M-1:0]     acc_mask;
    logic [M-1:0]     ovf_slot;
    logic [N-1:0]     ovf_hit;
    logic             accept;
    logic             found;
    logic [SW-1:0]    pick;

    arb_state_t       state;
    logic             valid_q;
    logic [SW-1:0]    slot_q;
    logic [SW-1:0]    last_q;
    logic [GAP_W-1:0] gap_cnt;

    for (genvar i = 0; i < N; i++) begin : g_ch
        edge_det #(
            .NE      (SPC),
            .RST_VAL (RST_VAL)
        ) u_det (
            .clk   (clk),
            .rst   (rst),
            .sig   (sig[i]),
            .edges (slot_edge[i*SPC +: SPC])
        );
    end

    assign accept = valid_q & evt.evt_ready;

    // Slot being retired this cycle and the overflow it may suppress.
    always_comb begin
        acc_mask = '0;
        if (accept) acc_mask[slot_q] = 1'b1;
        ovf_slot = slot_edge & pend & ~acc_mask;
        ovf_hit  = '0;
        for (int c = 0; c < N; c++) begin
            ovf_hit[c] = |ovf_slot[c*SPC +: SPC];
        end
    end

    // Round-robin pick: first pending slot after the last accepted one.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = last_q;
        for (int k = 1; k <= M; k++) begin
            idx = (int'(last_q) + k) % M;
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

    // Pending slots and sticky overflow; a same-cycle edge re-arms an accepted slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            ovf  <= '0;
        end else begin
            pend <= slot_edge | (pend & ~acc_mask);
            ovf  <= ovf_hit | (ovf & ~{N{ovf_clr}});
        end
    end

    // Offer sequencing with registered valid/slot outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            slot_q  <= '0;
            last_q  <= SW'(M - 1);
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= OFFER;
                        valid_q <= 1'b1;
                        slot_q  <= pick;
                    end
                end
                OFFER: begin
                    if (evt.evt_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= slot_q;
                        if (GAP_CYC > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign evt.evt_valid = valid_q;
`ifdef EDGE_EVT_ARB_FALL_EN
    assign evt.evt_id   = slot_q[SW-1:1];
    assign evt.evt_fall = slot_q[0];
`else
    assign evt.evt_id   = slot_q;
`endif

endmodule

// File: tb/tb_edge_evt_arb.sv
// Bench for edge_evt_arb: two instances (GAP_CYC 0 and 3) share the stimulus;
// directed scenarios plus a randomized run against a cycle-level reference.
module tb_edge_evt_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig;
    logic       ready;
    logic       ovf_clr;
    logic [3:0] ovf0, ovf3;

    int checks   = 0;
    int failures = 0;

    edge_evt_arb_if #(.N(4)) if0 ();
    edge_evt_arb_if #(.N(4)) if3 ();

    assign if0.evt_ready = ready;
    assign if3.evt_ready = ready;

    edge_evt_arb #(.N(4), .GAP_CYC(0), .RST_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sig(sig), .evt(if0), .ovf(ovf0), .ovf_clr(ovf_clr));
    edge_evt_arb #(.N(4), .GAP_CYC(3), .RST_VAL(1'b0)) dut3 (
        .clk(clk), .rst(rst), .sig(sig), .evt(if3), .ovf(ovf3), .ovf_clr(ovf_clr));

    always #5 clk = ~clk;

    // Reference: per channel one pending flag; after an acceptance the model
    // waits gap cycles, then arbitrates the next cycle from last+1.
    int         gap_of [2] = '{0, 3};
    bit         m_valid [2];
    int         m_id    [2];
    int         m_last  [2];
    int         m_wait  [2];
    bit [3:0]   m_pend  [2];
    bit [3:0]   m_ovf   [2];
    bit [3:0]   m_prev;

    always @(posedge clk) begin
        bit [3:0] rise, accbit, newp, setov;
        if (rst) begin
            m_prev = '0;
            for (int d = 0; d < 2; d++) begin
                m_valid[d] = 0; m_id[d] = 0; m_last[d] = 3; m_wait[d] = 0;
                m_pend[d] = '0; m_ovf[d] = '0;
            end
        end else begin
            rise   = sig & ~m_prev;
            m_prev = sig;
            for (int d = 0; d < 2; d++) begin
                accbit = '0;
                if (m_valid[d] && ready) accbit[m_id[d]] = 1'b1;
                setov = rise & m_pend[d] & ~accbit;
                newp  = rise | (m_pend[d] & ~accbit);
                if (accbit != 0) begin
                    m_valid[d] = 0;
                    m_last[d]  = m_id[d];
                    m_wait[d]  = gap_of[d];
                end else if (!m_valid[d]) begin
                    if (m_wait[d] > 0) m_wait[d]--;
                    else begin
                        for (int k = 1; k <= 4; k++) begin
                            if (!m_valid[d] && m_pend[d][(m_last[d] + k) % 4]) begin
                                m_valid[d] = 1;
                                m_id[d]    = (m_last[d] + k) % 4;
                            end
                        end
                    end
                end
                m_ovf[d]  = setov | (ovf_clr ? 4'b0 : m_ovf[d]);
                m_pend[d] = newp;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sig = '0; ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int j = 1; j <= 2; j++) begin
            @(negedge clk);
            checks++;
            if (if0.evt_valid !== 1'b0 || if0.evt_id !== 2'd0 || ovf0 !== 4'b0 ||
                if3.evt_valid !== 1'b0 || if3.evt_id !== 2'd0 || ovf3 !== 4'b0) begin
                failures++;
                $display("FAIL reset_state: got valid=%b/%b id=%0d/%0d ovf=%b/%b want 0,0,0",
                         if0.evt_valid, if3.evt_valid, if0.evt_id, if3.evt_id, ovf0, ovf3);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (if0.evt_valid !== 1'b0) begin
            failures++; $display("FAIL reset_first_cycle: got valid=%b want 0", if0.evt_valid);
        end
        @(negedge clk);
        checks++;
        if (if0.evt_valid !== 1'b1 || if0.evt_id !== 2'd0) begin
            failures++;
            $display("FAIL high_after_reset: got valid=%b id=%0d want 1 id=0", if0.evt_valid, if0.evt_id);
        end
    endtask

    task automatic test_single_edge();
        do_reset();
        ready = 1'b1; sig = 4'b0100;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            checks++;
            if (if0.evt_valid !== (j == 2) || (j == 2 && if0.evt_id !== 2'd2)) begin
                failures++;
                $display("FAIL single_edge t+%0d: got valid=%b id=%0d want valid=%b id=2",
                         j, if0.evt_valid, if0.evt_id, (j == 2));
            end
        end
    endtask

    task automatic test_simultaneous();
        bit exp_v;
        do_reset();
        ready = 1'b1; sig = 4'b1111;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            exp_v = (j >= 2 && j <= 8 && j % 2 == 0);
            checks++;
            if (if0.evt_valid !== exp_v || (exp_v && if0.evt_id !== 2'(j / 2 - 1))) begin
                failures++;
                $display("FAIL simultaneous t+%0d: got valid=%b id=%0d want valid=%b id=%0d",
                         j, if0.evt_valid, if0.evt_id, exp_v, j / 2 - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        ready = 1'b0; sig = 4'b0010;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k == 2) sig = 4'b0000;
            if (k == 3) sig = 4'b0010;
            checks++;
            if (if0.evt_valid !== 1'b1 || if0.evt_id !== 2'd1) begin
                failures++;
                $display("FAIL backpressure_hold k=%0d: got valid=%b id=%0d want 1 id=1",
                         k, if0.evt_valid, if0.evt_id);
            end
            @(negedge clk);
        end
        checks++;
        if (ovf0 !== 4'b0010) begin
            failures++; $display("FAIL backpressure_ovf: got %b want 0010", ovf0);
        end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (ovf0 !== 4'b0000) begin
            failures++; $display("FAIL ovf_clear: got %b want 0000", ovf0);
        end
        sig = 4'b0000;
        @(negedge clk);
        sig = 4'b0010; ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks++;
        if (ovf0 !== 4'b0010) begin
            failures++; $display("FAIL ovf_set_wins: got %b want 0010", ovf0);
        end
        ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (if0.evt_valid !== 1'b0 || ovf0 !== 4'b0010) begin
                failures++;
                $display("FAIL backpressure_drain j=%0d: got valid=%b ovf=%b want 0 ovf=0010",
                         j, if0.evt_valid, ovf0);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp_v;
        do_reset();
        ready = 1'b1; sig = 4'b0010;
        @(negedge clk); sig = 4'b0000;
        @(negedge clk); sig = 4'b0010;
        checks++;
        if (if0.evt_valid !== 1'b1 || if0.evt_id !== 2'd1) begin
            failures++;
            $display("FAIL reaccept_first: got valid=%b id=%0d want 1 id=1", if0.evt_valid, if0.evt_id);
        end
        for (int j = 3; j <= 5; j++) begin
            @(negedge clk);
            exp_v = (j == 4);
            checks++;
            if (if0.evt_valid !== exp_v || (exp_v && if0.evt_id !== 2'd1) || ovf0 !== 4'b0) begin
                failures++;
                $display("FAIL reaccept t+%0d: got valid=%b id=%0d ovf=%b want valid=%b id=1 ovf=0000",
                         j, if0.evt_valid, if0.evt_id, ovf0, exp_v);
            end
        end
    endtask

    task automatic test_gap();
        bit exp_v;
        do_reset();
        ready = 1'b1; sig = 4'b0101;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            exp_v = (j == 2 || j == 7);
            checks++;
            if (if3.evt_valid !== exp_v || (exp_v && if3.evt_id !== ((j == 2) ? 2'd0 : 2'd2))) begin
                failures++;
                $display("FAIL gap3 t+%0d: got valid=%b id=%0d want valid=%b",
                         j, if3.evt_valid, if3.evt_id, exp_v);
            end
            if (j == 4) begin
                checks++;
                if (if0.evt_valid !== 1'b1 || if0.evt_id !== 2'd2) begin
                    failures++;
                    $display("FAIL gap0_second: got valid=%b id=%0d want 1 id=2", if0.evt_valid, if0.evt_id);
                end
            end
        end
    endtask

    task automatic test_rst_during_offer();
        do_reset();
        ready = 1'b1; sig = 4'b0100;
        repeat (3) @(negedge clk);
        ready = 1'b0; sig = 4'b0101;
        repeat (2) @(negedge clk);
        checks++;
        if (if0.evt_valid !== 1'b1 || if0.evt_id !== 2'd0) begin
            failures++;
            $display("FAIL rr_after_2: got valid=%b id=%0d want 1 id=0", if0.evt_valid, if0.evt_id);
        end
        sig = 4'b0100;
        @(negedge clk); sig = 4'b0101;
        @(negedge clk);
        checks++;
        if (ovf0 !== 4'b0001) begin
            failures++; $display("FAIL pre_rst_ovf: got %b want 0001", ovf0);
        end
        rst = 1'b1; sig = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (if0.evt_valid !== 1'b0 || ovf0 !== 4'b0 || if3.evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_offer: got valid=%b/%b ovf=%b want 0 ovf=0000",
                     if0.evt_valid, if3.evt_valid, ovf0);
        end
        ready = 1'b1; sig = 4'b1010;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            if (j == 2 || j == 4) begin
                checks++;
                if (if0.evt_valid !== 1'b1 || if0.evt_id !== ((j == 2) ? 2'd1 : 2'd3)) begin
                    failures++;
                    $display("FAIL rst_priority t+%0d: got valid=%b id=%0d want 1 id=%0d",
                             j, if0.evt_valid, if0.evt_id, (j == 2) ? 1 : 3);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if (if0.evt_valid !== m_valid[0] || (m_valid[0] && if0.evt_id !== 2'(m_id[0])) ||
                ovf0 !== m_ovf[0]) begin
                failures++;
                $display("FAIL random_gap0 c=%0d: got valid=%b id=%0d ovf=%b want valid=%b id=%0d ovf=%b",
                         c, if0.evt_valid, if0.evt_id, ovf0, m_valid[0], m_id[0], m_ovf[0]);
            end
            checks++;
            if (if3.evt_valid !== m_valid[1] || (m_valid[1] && if3.evt_id !== 2'(m_id[1])) ||
                ovf3 !== m_ovf[1]) begin
                failures++;
                $display("FAIL random_gap3 c=%0d: got valid=%b id=%0d ovf=%b want valid=%b id=%0d ovf=%b",
                         c, if3.evt_valid, if3.evt_id, ovf3, m_valid[1], m_id[1], m_ovf[1]);
            end
            rst     = ($urandom_range(0, 199) == 0);
            sig     = sig ^ (4'($urandom) & 4'($urandom));
            ready   = ($urandom_range(0, 9) < 7);
            ovf_clr = ($urandom_range(0, 19) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sig = 4'b0001; ready = 1'b1; ovf_clr = 1'b0;
        test_reset();
        test_single_edge();
        test_simultaneous();
        test_backpressure();
        test_back_to_back();
        test_gap();
        test_rst_during_offer();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_evt_arb.md
EDGE_EVT_ARB -- requirements
Module: edge_evt_arb

Interface
REQ-001 Parameter N, default 4: number of event channels, legal range 2..16.
REQ-002 Parameter GAP_CYC, default 0: idle cycles enforced after each accepted event, legal range 0..255.
REQ-003 Parameter RST_VAL, default 0: reset value of every channel's previous-sample register.
REQ-004 clk  input  1: single clock; all logic is on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 sig  input  N: per-channel level inputs, already synchronous to clk.
REQ-007 evt_valid  output  1: an event is offered to the consumer.
REQ-008 evt_id  output  $clog2(N): channel index of the offered event.
REQ-009 evt_ready  input  1: consumer accepts the offered event.
REQ-010 ovf  output  N: sticky per-channel overflow flags.
REQ-011 ovf_clr  input  1: clears all ovf bits.

Function
REQ-012 Rising edge on channel i is sig[i]=1 with prev[i]=0; prev[i] <= sig[i] every cycle.
REQ-013 An edge sets pend[i] at the end of the cycle in which the edge occurs.
REQ-014 FSM states: IDLE, OFFER, GAP; reset state IDLE.
REQ-015 IDLE with any pend bit set -> OFFER next cycle, latching evt_id by round-robin; otherwise stay IDLE.
REQ-016 Round-robin search starts at last_id+1 mod N; last_id resets to N-1, so channel 0 wins first.
REQ-017 OFFER drives evt_valid=1, holding evt_id stable until evt_valid&evt_ready.
REQ-018 On acceptance: pend[evt_id] clears, last_id <= evt_id, next state GAP if GAP_CYC>0, else IDLE.
REQ-019 GAP counts GAP_CYC cycles with evt_valid=0, then -> IDLE.
REQ-020 Latency: edge in cycle t, no contention -> evt_valid first high in cycle t+2.
REQ-021 Edge on channel i while pend[i]=1 and not accepted that cycle -> ovf[i] set, pend[i] stays 1.
REQ-022 Edge on channel i in the same cycle it is accepted -> pend[i] stays 1, no overflow.
REQ-023 ovf_clr coincident with a new overflow on the same channel -> that ovf bit is 1 (set wins).
REQ-024 Accepted events never reorder per channel; at most one pending event per channel.

Reset
REQ-025 While rst=1: evt_valid=0, evt_id=0, ovf=0, pend=0, prev=RST_VAL for every bit, gap counter=0, state IDLE, last_id=N-1.
REQ-026 rst asserted during OFFER or GAP discards the event in flight; no acceptance is reported.
REQ-027 Edges in the reset cycle are ignored.
REQ-028 With RST_VAL=0, a channel high in the first cycle after reset registers a rising edge.

Configuration
REQ-029 Macro EDGE_EVT_ARB_FALL_EN defined: falling edges are also events, with separate pend_r/pend_f per channel and an extra output evt_fall (1 bit, 1 = falling).
REQ-030 With the macro, round-robin runs over 2N slots in the order ch0 rise, ch0 fall, ch1 rise, ...; all other rules apply per slot, with ovf per channel as the OR of both slots.
REQ-031 Macro undefined: falling edges are ignored and evt_fall does not exist.

Structure
REQ-032 Package edge_evt_arb_pkg holds the FSM state enum (IDLE/OFFER/GAP) and the id-width function.
REQ-033 Per-channel edge detection (prev register, rise/fall outputs) is sub-module edge_det, instantiated N times.

Verification
REQ-034 Single edge: N=4, rise sig[2] at t, evt_ready=1 -> evt_valid high at t+2 with evt_id=2 for one cycle.
REQ-035 Simultaneous edges on all 4 channels, ready=1 -> ids 0,1,2,3 in order, with 1 idle cycle between offers.
REQ-036 Backpressure: evt_ready=0 for 10 cycles -> evt_valid and evt_id held constant; second edge on the same channel sets ovf bit.
REQ-037 Edge on ch1 in the cycle ch1 is accepted -> ch1 offered again, ovf[1]=0.
REQ-038 GAP_CYC=3 -> exactly 3 cycles with evt_valid=0 after acceptance, then 1 IDLE cycle, then next offer.
REQ-039 rst pulsed during OFFER -> next cycle evt_valid=0, ovf=0, and the next edge is offered from channel 0 priority.
